// File: rtl/fifo_param_pkg.sv
// rtl/fifo_param_pkg.sv - shared transaction-layer FIFO defaults and operation encoding
package fifo_param_pkg;

    localparam int FIFO_DATA_WIDTH = 10;
    localparam int FIFO_ADDR_WIDTH = 4;

    // Encoded as {read_accepted, write_accepted}
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/memoria_param.sv
// rtl/memoria_param.sv - FIFO storage array, synchronous write and addressed read
module memoria_param
    import fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // No reset: contents are never relied upon after reset
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parameterised synchronous FIFO with threshold flags and sticky error
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    fifo_op_e              op;

    memoria_param #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (wr_acc),
        .wr_addr(wr_ptr_q),
        .wr_data(data_in),
        .rd_addr(rd_ptr_q),
        .rd_data(mem_rd_data)
    );

    always_comb begin
        // When full, a simultaneous read frees the slot the write lands in
        wr_acc     = wr_en && ((count_q != DEPTH) || rd_en);
        rd_acc     = rd_en && (count_q != '0);
        op         = fifo_op_e'({rd_acc, wr_acc});
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = rd_acc;
        error_d    = error_q | (wr_en & ~wr_acc) | (rd_en & ~rd_acc);

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = mem_rd_data;
        end

        case (op)
            OP_WRITE: count_d = count_q + 1'b1;
            OP_READ:  count_d = count_q - 1'b1;
            default:  count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_q;
    assign count        = count_q;
    assign error        = error_q;
    assign full         = (count_q == DEPTH);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= umbral_alto);
    assign almost_empty = (count_q <= umbral_bajo);

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - randomized and directed self-checking bench for fifo_param
module tb_fifo_param;

    localparam int DW    = 10;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [AW:0]   umbral_alto = 5'd12;
    logic [AW:0]   umbral_bajo = 5'd3;
    logic [DW-1:0] data_out;
    logic          valid_out, full, empty, almost_full, almost_empty, error;
    logic [AW:0]   count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of stored words plus the registered outputs
    int m_q[$];
    int m_dout  = 0;
    bit m_valid = 0;
    bit m_err   = 0;

    fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_L(reset_L), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        check_val("count", 32'(count), 32'(n));
        check_val("full", 32'(full), 32'(n == DEPTH));
        check_val("empty", 32'(empty), 32'(n == 0));
        check_val("almost_full", 32'(almost_full), 32'(n >= int'(umbral_alto)));
        check_val("almost_empty", 32'(almost_empty), 32'(n <= int'(umbral_bajo)));
        check_val("valid_out", 32'(valid_out), 32'(m_valid));
        check_val("error", 32'(error), 32'(m_err));
        check_val("data_out", 32'(data_out), 32'(m_dout));
    endtask

    // Drive one cycle from a negedge, advance the model, compare at the next negedge
    task automatic cycle(input bit w, input bit r, input int d);
        int  n;
        bit  wa, ra;
        wr_en   = w;
        rd_en   = r;
        data_in = DW'(d);
        n  = m_q.size();
        wa = w && (n < DEPTH || (r && n == DEPTH));
        ra = r && n > 0;
        if ((w && !wa) || (r && !ra)) m_err = 1;
        m_valid = ra;
        if (ra) m_dout = m_q.pop_front();
        if (wa) m_q.push_back(d);
        @(posedge clk);
        @(negedge clk);
        wr_en = 0;
        rd_en = 0;
        check_all();
    endtask

    // Assert reset between edges so the outputs can only have changed asynchronously
    task automatic do_reset();
        wr_en = 0;
        rd_en = 0;
        #2 reset_L = 0;
        #1;
        m_q.delete();
        m_dout  = 0;
        m_valid = 0;
        m_err   = 0;
        check_all();
        @(negedge clk);
        reset_L = 1;
        check_all();
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Four-word write then read-back
        cycle(1, 0, 'h0FF); cycle(1, 0, 'h011); cycle(1, 0, 'h022); cycle(1, 0, 'h033);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0);
        check_val("seq4_last", 32'(data_out), 32'h033);
        check_val("seq4_empty", 32'(empty), 32'd1);
        cycle(0, 0, 0);

        // Fill to full, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, i);
        check_val("fill_count", 32'(count), 32'd16);
        cycle(1, 0, 'h3FF);
        check_val("overflow_err", 32'(error), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, 0);
            check_val("drain_word", 32'(data_out), 32'(i));
        end

        // Threshold edges while filling
        do_reset();
        umbral_alto = 5'd12;
        umbral_bajo = 5'd3;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0, 'h100 + i);
            if (i == 10) check_val("af_below", 32'(almost_full), 32'd0);
            if (i == 11) check_val("af_rise", 32'(almost_full), 32'd1);
            if (i == 2)  check_val("ae_hold", 32'(almost_empty), 32'd1);
            if (i == 3)  check_val("ae_fall", 32'(almost_empty), 32'd0);
        end

        // Full FIFO with simultaneous read and write across pointer wrap
        for (int i = 0; i < 20; i++) cycle(1, 1, 'h200 + i);
        check_val("rw_full_count", 32'(count), 32'd16);
        check_val("rw_full_err", 32'(error), 32'd0);

        // Underflow with simultaneous write
        do_reset();
        cycle(1, 1, 'h155);
        check_val("uf_err", 32'(error), 32'd1);
        check_val("uf_count", 32'(count), 32'd1);
        cycle(0, 1, 0);
        check_val("uf_data", 32'(data_out), 32'h155);

        // Reset mid-burst at count 9
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1, 0, 'h050 + i);
        do_reset();
        check_val("rst_empty", 32'(empty), 32'd1);
        cycle(1, 0, 'h2AA);
        cycle(0, 1, 0);
        check_val("rst_first", 32'(data_out), 32'h2AA);

        // Randomized traffic with phases biased toward filling and draining
        for (int seg = 0; seg < 8; seg++) begin
            int wp;
            umbral_alto = 5'($urandom_range(0, 17));
            umbral_bajo = 5'($urandom_range(0, 17));
            wp = (seg % 2 == 0) ? 75 : 25;
            if (seg == 5) do_reset();
            for (int i = 0; i < 80; i++) begin
                bit w, r;
                w = ($urandom_range(0, 99) < wp);
                r = ($urandom_range(0, 99) < (100 - wp));
                cycle(w, r, int'($urandom_range(0, 1023)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DATA_WIDTH, default 10, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, pointer width; DEPTH = 2**ADDR_WIDTH (16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write request.
REQ-006 rd_en  input  1  read request.
REQ-007 data_in  input  DATA_WIDTH  write data.
REQ-008 umbral_alto  input  ADDR_WIDTH+1  almost-full threshold.
REQ-009 umbral_bajo  input  ADDR_WIDTH+1  almost-empty threshold.
REQ-010 data_out  output  DATA_WIDTH  registered read data.
REQ-011 valid_out  output  1  data_out carries a word popped on the previous edge.
REQ-012 full, empty  output  1 each  occupancy flags.
REQ-013 almost_full, almost_empty  output  1 each  threshold flags.
REQ-014 count  output  ADDR_WIDTH+1  words stored, 0..DEPTH.
REQ-015 error  output  1  sticky overflow/underflow flag.

Function
REQ-016 The FIFO SHALL evaluate every accept decision against the pre-edge count.
REQ-017 A write SHALL be accepted when wr_en=1 and count<DEPTH, or when wr_en=1, rd_en=1 and count=DEPTH.
REQ-018 A read SHALL be accepted when rd_en=1 and count>0.
REQ-019 An accepted write SHALL store data_in at wr_ptr and advance wr_ptr modulo DEPTH.
REQ-020 An accepted read SHALL place mem[rd_ptr] on data_out one edge later, pulse valid_out=1 for that cycle, and advance rd_ptr modulo DEPTH.
REQ-021 valid_out SHALL be 0 in every cycle not following an accepted read.
REQ-022 data_out SHALL hold its last value while no read is accepted.
REQ-023 count SHALL change by +1 (write only), -1 (read only) or 0 (both or neither).
REQ-024 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both decoded from registered count.
REQ-025 almost_full SHALL equal (count>=umbral_alto) and almost_empty SHALL equal (count<=umbral_bajo).
REQ-026 A rejected write (wr_en=1, full, rd_en=0) SHALL be dropped and SHALL set error.
REQ-027 A rejected read (rd_en=1, empty) SHALL leave pointers unchanged and SHALL set error; a simultaneous write SHALL still be accepted.
REQ-028 Once set, error SHALL remain 1 until reset.
REQ-029 Pointer wrap from DEPTH-1 to 0 SHALL introduce no bubble or data loss.

Reset
REQ-030 While reset_L=0, asynchronously: wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, error=0.
REQ-031 Consequently during reset: empty=1, full=0; almost flags follow REQ-025 with count=0.
REQ-032 Memory contents SHALL be neither cleared nor relied upon after reset.
REQ-033 A reset asserted mid-operation SHALL discard all stored words; the first accepted read after release SHALL return the first word written after release.

Structure
REQ-034 Storage SHALL be one sub-module, memoria_param (DATA_WIDTH, ADDR_WIDTH parameters; synchronous write, addressed read), instantiated once.
REQ-035 Default DATA_WIDTH and ADDR_WIDTH SHALL reside in the shared transaction-layer parameter include file, used by all FIFOs of the layer.
REQ-036 Pointer, count, flag and error logic SHALL reside in fifo_param; no latches; synthesised netlist SHALL match behavioural model cycle by cycle.

Verification
REQ-037 Reset, write 0x0FF,0x011,0x022,0x033 then read 4 -> data_out 0x0FF,0x011,0x022,0x033 each with valid_out=1 one edge after rd_en; empty=1 at end.
REQ-038 Write 16 words 0x000..0x00F -> full=1, count=16; 17th write 0x3FF -> dropped, error=1; reading 16 returns 0x000..0x00F.
REQ-039 umbral_alto=12, umbral_bajo=3: fill 0..16 -> almost_full rises at count=12, almost_empty falls at count=4.
REQ-040 From count=16 assert wr_en and rd_en 20 cycles with incrementing data -> count stays 16, error=0, output order intact across wrap.
REQ-041 Empty FIFO, rd_en=1 with wr_en=1 data 0x155 -> error=1, count=1, next read returns 0x155.
REQ-042 Reset asserted at count=9 mid-burst -> all outputs at reset values immediately (async); after release write 0x2AA, read -> 0x2AA.
